// File: rtl/pll_reset_sequencer_pkg.sv
// Shared types and constants for the PLL reset sequencer.
// Optional loss-of-lock counter is built when PLL_LOSS_COUNT_EN is defined.
package pll_seq_pkg;

    localparam int RETRY_W = 4;
    localparam int LOSS_W  = 8;

    localparam int DEF_RST_HOLD_CYCLES     = 50;
    localparam int DEF_LOCK_TIMEOUT_CYCLES = 50000;
    localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
    localparam int DEF_MAX_RETRIES         = 3;

    typedef enum logic [2:0] {
        ST_RESET_PLL = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4
    } pll_seq_state_t;

    // Counter width for a count of n cycles; at least one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pll_reset_sequencer_if.sv
// PLL-side and system-side signals of the reset sequencer.
// master = sequencer, slave = PLL / downstream environment.
interface pll_reset_sequencer_if;
    import pll_seq_pkg::*;

    logic               pll_locked;
    logic               restart;
    logic               pll_rst;
    logic               sys_rst;
    logic               ready;
    logic               fault;
    logic [RETRY_W-1:0] retry_cnt;
    logic [LOSS_W-1:0]  loss_cnt;

    modport master (
        input  pll_locked, restart,
        output pll_rst, sys_rst, ready, fault, retry_cnt, loss_cnt
    );

    modport slave (
        output pll_locked, restart,
        input  pll_rst, sys_rst, ready, fault, retry_cnt, loss_cnt
    );

endinterface

// File: rtl/pll_reset_sequencer_lock_sync.sv
// Two-flop synchronizer bringing the raw PLL locked flag into refclk.
// Both flops carry the async-register timing attribute.
module pll_lock_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    (* ASYNC_REG = "TRUE" *) logic [1:0] sync_q;

    // Shift the asynchronous input through two flops.
    always_ff @(posedge clk_i) begin
        if (rst_i) sync_q <= 2'b00;
        else       sync_q <= {sync_q[0], d_i};
    end

    assign q_o = sync_q[1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL power-up / recovery sequencer running on the reference clock.
// Define PLL_LOSS_COUNT_EN to build the saturating loss-of-lock counter.
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int RST_HOLD_CYCLES     = DEF_RST_HOLD_CYCLES,
    parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
    parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
    parameter int MAX_RETRIES         = DEF_MAX_RETRIES
) (
    input  logic                  refclk,
    input  logic                  rst,
    pll_reset_sequencer_if.master bus
);

    localparam logic [2:0] RESET_PLL = ST_RESET_PLL;
    localparam logic [2:0] WAIT_LOCK = ST_WAIT_LOCK;
    localparam logic [2:0] STABLE    = ST_STABLE;
    localparam logic [2:0] RUN       = ST_RUN;
    localparam logic [2:0] FAULT     = ST_FAULT;

    localparam int HOLD_W = cnt_w(RST_HOLD_CYCLES);
    localparam int TO_W   = cnt_w(LOCK_TIMEOUT_CYCLES);
    localparam int STB_W  = cnt_w(LOCK_STABLE_CYCLES);

    localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(RST_HOLD_CYCLES - 1);
    localparam logic [TO_W-1:0]    TO_LAST   = TO_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [STB_W-1:0]   STB_LAST  = STB_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);

    logic               lock_s;
    logic [2:0]         state_q, state_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [TO_W-1:0]    to_q, to_d;
    logic [STB_W-1:0]   stb_q, stb_d;
    logic [RETRY_W-1:0] retry_q, retry_d, retry_inc;
    logic               pll_rst_q, sys_rst_q, ready_q, fault_q;

    pll_lock_sync u_sync (
        .clk_i (refclk),
        .rst_i (rst),
        .d_i   (bus.pll_locked),
        .q_o   (lock_s)
    );

    assign retry_inc = retry_q + 1'b1;

    // Next-state logic: restart beats timeout, timeout beats lock events.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        to_d    = to_q;
        stb_d   = stb_q;
        retry_d = retry_q;
        if (bus.restart) begin
            state_d = RESET_PLL;
            retry_d = '0;
            hold_d  = '0;
            to_d    = '0;
            stb_d   = '0;
        end else begin
            unique case (state_q)
                RESET_PLL: begin
                    if (hold_q == HOLD_LAST) state_d = WAIT_LOCK;
                    else                     hold_d  = hold_q + 1'b1;
                end
                WAIT_LOCK, STABLE: begin
                    to_d = to_q + 1'b1;
                    if (to_q == TO_LAST) begin
                        retry_d = retry_inc;
                        state_d = (retry_inc == RETRY_MAX) ? FAULT : RESET_PLL;
                        hold_d  = '0;
                        to_d    = '0;
                        stb_d   = '0;
                    end else if (state_q == WAIT_LOCK) begin
                        if (lock_s) begin
                            state_d = STABLE;
                            stb_d   = STB_W'(1);
                        end
                    end else if (!lock_s) begin
                        state_d = WAIT_LOCK;
                        stb_d   = '0;
                    end else if (stb_q == STB_LAST) begin
                        state_d = RUN;
                        retry_d = '0;
                    end else begin
                        stb_d = stb_q + 1'b1;
                    end
                end
                RUN: begin
                    if (!lock_s) begin
                        state_d = RESET_PLL;
                        hold_d  = '0;
                        to_d    = '0;
                        stb_d   = '0;
                    end
                end
                FAULT: begin
                end
                default: state_d = RESET_PLL;
            endcase
        end
    end

    // State, counters and outputs decoded from the next state.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q   <= RESET_PLL;
            hold_q    <= '0;
            to_q      <= '0;
            stb_q     <= '0;
            retry_q   <= '0;
            pll_rst_q <= 1'b1;
            sys_rst_q <= 1'b1;
            ready_q   <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            to_q      <= to_d;
            stb_q     <= stb_d;
            retry_q   <= retry_d;
            pll_rst_q <= (state_d == RESET_PLL) || (state_d == FAULT);
            sys_rst_q <= (state_d != RUN);
            ready_q   <= (state_d == RUN);
            fault_q   <= (state_d == FAULT);
        end
    end

`ifdef PLL_LOSS_COUNT_EN
    logic [LOSS_W-1:0] loss_q;
    logic              loss_inc;

    assign loss_inc = (state_q == RUN) && !lock_s && !bus.restart;

    // Saturating count of lock losses seen while running.
    always_ff @(posedge refclk) begin
        if (rst)                          loss_q <= '0;
        else if (loss_inc && loss_q != '1) loss_q <= loss_q + 1'b1;
    end

    assign bus.loss_cnt = loss_q;
`else
    assign bus.loss_cnt = '0;
`endif

    assign bus.pll_rst   = pll_rst_q;
    assign bus.sys_rst   = sys_rst_q;
    assign bus.ready     = ready_q;
    assign bus.fault     = fault_q;
    assign bus.retry_cnt = retry_q;

endmodule
